// File: rtl/mux_scan_sampler_if.sv
// Signal bundle between the PUF cell array / readout logic and mux_scan_sampler.
// master drives channel inputs and scan controls; slave is the sampler itself.
interface mux_scan_sampler_if #(
  parameter int N_CH  = 16,
  parameter int SEL_W = $clog2(N_CH)
);
  logic [N_CH-1:0]  din;
  logic             start;
  logic             abort;
  logic             manual_en;
  logic [SEL_W-1:0] manual_sel;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_out;
  logic             busy;
  logic             sample_valid;
  logic [SEL_W-1:0] sample_ch;
  logic             sample_bit;
  logic [N_CH-1:0]  resp;
  logic             done;

  modport master (
    output din, start, abort, manual_en, manual_sel,
    input  mux_sel, mux_out, busy, sample_valid, sample_ch, sample_bit, resp, done
  );

  modport slave (
    input  din, start, abort, manual_en, manual_sel,
    output mux_sel, mux_out, busy, sample_valid, sample_ch, sample_bit, resp, done
  );
endinterface

// File: rtl/mux_scan_sampler.sv
// N-channel registered selector with a scan sequencer that sweeps all channels into resp.
// Optional macro MUX_SCAN_MAJORITY_EN: 3-read 2-of-3 majority capture per channel.
module mux_scan_sampler #(
  parameter int N_CH   = 16,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int SETTLE = 4
) (
  input logic               clk,
  input logic               rst,
  mux_scan_sampler_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  resp_q, resp_d;
  logic             busy_q, done_q, sample_valid_q, sample_bit_q, mux_out_q;
  logic [SEL_W-1:0] sample_ch_q;
  logic [SEL_W-1:0] mux_sel;
  logic             cap_en, cap_bit, din_cur, abort_hit;
`ifdef MUX_SCAN_MAJORITY_EN
  logic [1:0]       vote_idx_q, vote_idx_d;
  logic [1:0]       votes_q, votes_d;
`endif

  assign din_cur   = bus.din[cur_ch_q];
  assign abort_hit = bus.abort && (state_q != S_IDLE);

  always_comb begin
    mux_sel = '0;
    if (busy_q) begin
      mux_sel = cur_ch_q;
    end else if (state_q == S_IDLE && bus.manual_en) begin
      mux_sel = bus.manual_sel;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    resp_d   = resp_q;
    cap_en   = 1'b0;
    cap_bit  = din_cur;
`ifdef MUX_SCAN_MAJORITY_EN
    vote_idx_d = vote_idx_q;
    votes_d    = votes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.manual_en) begin
          state_d  = S_SETTLE;
          cur_ch_d = '0;
          cnt_d    = CNT_LOAD;
          resp_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
`ifdef MUX_SCAN_MAJORITY_EN
          vote_idx_d = 2'd0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
`ifdef MUX_SCAN_MAJORITY_EN
        // First two reads are stored as votes; the third read resolves the majority.
        if (vote_idx_q != 2'd2) begin
          votes_d[vote_idx_q[0]] = din_cur;
          vote_idx_d             = vote_idx_q + 2'd1;
        end else begin
          cap_en  = 1'b1;
          cap_bit = (votes_q[0] & votes_q[1]) | (votes_q[0] & din_cur) | (votes_q[1] & din_cur);
        end
`else
        cap_en = 1'b1;
`endif
        if (cap_en) begin
          resp_d[cur_ch_q] = cap_bit;
          if (cur_ch_q == LAST_CH) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_SETTLE;
            cur_ch_d = cur_ch_q + 1'b1;
            cnt_d    = CNT_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over any capture in the same cycle; partial resp is kept.
    if (abort_hit) begin
      state_d = S_IDLE;
      cap_en  = 1'b0;
      resp_d  = resp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cur_ch_q       <= '0;
      cnt_q          <= '0;
      resp_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_bit_q   <= 1'b0;
      mux_out_q      <= 1'b0;
`ifdef MUX_SCAN_MAJORITY_EN
      vote_idx_q     <= '0;
      votes_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cur_ch_q       <= cur_ch_d;
      cnt_q          <= cnt_d;
      resp_q         <= resp_d;
      busy_q         <= !abort_hit && (state_q == S_SETTLE || state_q == S_SAMPLE);
      done_q         <= !abort_hit && (state_q == S_DONE);
      sample_valid_q <= cap_en;
      if (cap_en) begin
        sample_ch_q  <= cur_ch_q;
        sample_bit_q <= cap_bit;
      end
      mux_out_q      <= (int'(mux_sel) < N_CH) ? bus.din[mux_sel] : 1'b0;
`ifdef MUX_SCAN_MAJORITY_EN
      vote_idx_q     <= vote_idx_d;
      votes_q        <= votes_d;
`endif
    end
  end

  assign bus.mux_sel      = mux_sel;
  assign bus.mux_out      = mux_out_q;
  assign bus.busy         = busy_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_bit   = sample_bit_q;
  assign bus.resp         = resp_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: manual mux, full scans, abort, back-to-back, reset.
// Cycle c means the interval just after the c-th rising edge, the start edge being edge 0.
module tb_mux_scan_sampler;
  localparam int N_CH   = 16;
  localparam int SEL_W  = 4;
  localparam int SETTLE = 4;
`ifdef MUX_SCAN_MAJORITY_EN
  localparam int SAMP = 3;
`else
  localparam int SAMP = 1;
`endif
  localparam int P        = SETTLE + SAMP;
  localparam int DONE_CYC = N_CH * P + 1;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mux_scan_sampler_if #(.N_CH(N_CH), .SEL_W(SEL_W)) bus ();

  mux_scan_sampler #(.N_CH(N_CH), .SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [28:0] obs;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    obs = {bus.mux_sel, bus.mux_out, bus.busy, bus.sample_valid, bus.sample_ch,
           bus.sample_bit, bus.resp, bus.done};
    vectors++;
    if (obs !== 29'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %h expected 0", obs);
    end
  endtask

  task automatic test_manual();
    logic [15:0] pat = 16'hAAAA;
    bus.manual_en = 1'b1;
    bus.din       = pat;
    for (int s = 0; s < N_CH; s++) begin
      bus.manual_sel = SEL_W'(s);
      #1;
      vectors++;
      if (bus.mux_sel !== SEL_W'(s)) begin
        miscompares++;
        $display("[TB] FAIL manual_sel sel=%0d got %0d expected %0d", s, bus.mux_sel, s);
      end
      step();
      vectors++;
      if (bus.mux_out !== pat[s]) begin
        miscompares++;
        $display("[TB] FAIL manual_out sel=%0d got %b expected %b", s, bus.mux_out, pat[s]);
      end
      for (int k = 0; k < 4; k++) step();
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL manual_busy sel=%0d got %b expected 0", s, bus.busy);
      end
    end
    // Start must be ignored while manual mode is selected.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL manual_start_ignored got busy=%b expected 0", bus.busy);
      end
    end
    bus.manual_en  = 1'b0;
    bus.manual_sel = '0;
    step();
  endtask

  task automatic test_full_scan(input logic [15:0] pat, input int extra_a, input int extra_b);
    logic [2:0] exp_f, obs_f;
    int         ch;
    bus.din   = pat;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    vectors++;
    if (bus.resp !== 16'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL scan_cyc0 resp=%h busy=%b expected resp=0 busy=0", bus.resp, bus.busy);
    end
    for (int cyc = 1; cyc <= DONE_CYC + 1; cyc++) begin
      step();
      exp_f = {(cyc >= 1 && cyc <= N_CH * P), (cyc == DONE_CYC),
               (cyc % P == 0 && cyc >= P && cyc <= N_CH * P)};
      obs_f = {bus.busy, bus.done, bus.sample_valid};
      vectors++;
      if (obs_f !== exp_f) begin
        miscompares++;
        $display("[TB] FAIL scan_flags cyc=%0d busy/done/valid got %b expected %b", cyc, obs_f, exp_f);
      end
      if (exp_f[0] && cyc % P == 0) begin
        ch = cyc / P - 1;
        vectors++;
        if (bus.sample_ch !== SEL_W'(ch) || bus.sample_bit !== pat[ch]) begin
          miscompares++;
          $display("[TB] FAIL scan_sample cyc=%0d ch/bit got %0d/%b expected %0d/%b",
                   cyc, bus.sample_ch, bus.sample_bit, ch, pat[ch]);
        end
      end
      if (exp_f[2] == 1'b0 && cyc <= N_CH * P && cyc % P == 2) begin
        vectors++;
        if (bus.mux_sel !== SEL_W'(cyc / P)) begin
          miscompares++;
          $display("[TB] FAIL scan_mux_sel cyc=%0d got %0d expected %0d", cyc, bus.mux_sel, cyc / P);
        end
      end
      if (cyc <= N_CH * P && cyc % P == 3) begin
        vectors++;
        if (bus.mux_out !== pat[cyc / P]) begin
          miscompares++;
          $display("[TB] FAIL scan_mux_out cyc=%0d got %b expected %b", cyc, bus.mux_out, pat[cyc / P]);
        end
      end
      bus.start = (cyc == extra_a || cyc == extra_b);
    end
    bus.start = 1'b0;
    vectors++;
    if (bus.resp !== pat) begin
      miscompares++;
      $display("[TB] FAIL scan_resp got %h expected %h", bus.resp, pat);
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp_a = 16'((1 << (23 / P)) - 1);
    bus.din   = 16'hFFFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 23; cyc++) step();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_pre_busy got %b expected 1", bus.busy);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    vectors++;
    if ({bus.busy, bus.sample_valid, bus.resp, bus.mux_sel} !== {2'b00, exp_a, 4'h0}) begin
      miscompares++;
      $display("[TB] FAIL abort_state busy=%b valid=%b resp=%h sel=%0d expected 0/0/%h/0",
               bus.busy, bus.sample_valid, bus.resp, bus.mux_sel, exp_a);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_quiet done=%b busy=%b expected 0/0", bus.done, bus.busy);
      end
    end
    // Abort landing on the first SAMPLE cycle of channel 2 must block that capture.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= SETTLE + 2 * P; cyc++) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    vectors++;
    if (bus.resp !== 16'h0003 || bus.sample_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_in_sample resp=%h valid=%b expected 0003/0", bus.resp, bus.sample_valid);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    step();
    vectors++;
    if (bus.busy !== 1'b0 || bus.resp !== 16'h0003) begin
      miscompares++;
      $display("[TB] FAIL abort_idle busy=%b resp=%h expected 0/0003", bus.busy, bus.resp);
    end
  endtask

  task automatic test_back_to_back();
    test_full_scan(16'hAAAA, 10, N_CH * P);
    test_full_scan(16'h5555, -1, -1);
  endtask

  task automatic test_reset_mid_scan();
    logic [28:0] obs;
    bus.din   = 16'hAAAA;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs = {bus.mux_sel, bus.mux_out, bus.busy, bus.sample_valid, bus.sample_ch,
           bus.sample_bit, bus.resp, bus.done};
    vectors++;
    if (obs !== 29'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_scan got %h expected 0", obs);
    end
    test_full_scan(16'h3C5A, -1, -1);
  endtask

`ifdef MUX_SCAN_MAJORITY_EN
  task automatic test_majority();
    bus.din   = 16'h0000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= DONE_CYC; cyc++) begin
      step();
      if (cyc == 6 * P || cyc == 10 * P) begin
        vectors++;
        if (bus.sample_valid !== 1'b1 || bus.sample_bit !== (cyc == 10 * P)) begin
          miscompares++;
          $display("[TB] FAIL majority_bit cyc=%0d valid=%b bit=%b expected 1/%b",
                   cyc, bus.sample_valid, bus.sample_bit, (cyc == 10 * P));
        end
      end
      if (cyc == DONE_CYC) begin
        vectors++;
        if (bus.done !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL majority_done cyc=%0d got %b expected 1", cyc, bus.done);
        end
      end
      // ch5 sees one high read out of three, ch9 sees two.
      if (cyc == 5 * P + SETTLE + 1) bus.din = 16'h0020;
      else if (cyc == 9 * P + SETTLE || cyc == 9 * P + SETTLE + 1) bus.din = 16'h0200;
      else bus.din = 16'h0000;
    end
    vectors++;
    if (bus.resp !== 16'h0200) begin
      miscompares++;
      $display("[TB] FAIL majority_resp got %h expected 0200", bus.resp);
    end
    step();
  endtask
`endif

  initial begin
    rst            = 1'b1;
    bus.din        = '0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.manual_en  = 1'b0;
    bus.manual_sel = '0;
    test_reset();
    test_manual();
    test_full_scan(16'hAAAA, -1, -1);
    test_abort();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef MUX_SCAN_MAJORITY_EN
    test_majority();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
